i2c_read_data_b: RTL and testbench

I2C master read stage that runs directly after the 2-byte pointer write on the D8M configuration bus. It issues START, the slave address with R/W=1, then clocks in BYTES data bytes from the register selected by the preceding pointer write, ACKing all but the last and NACKing the last, and finishes with STOP. It shares the PT_CK bit-tick, open-drain SDAO/SCLO drive and GO/END_OK handshake with the pointer-write stage, so the configuration sequencer can alternate the two on one bus through a mux.

---
 rtl/i2c_b_pkg.sv | 48 ++++
 rtl/i2c_byte_shifter_b.sv | 36 +++
 rtl/i2c_read_data_b.sv | 252 +++++++++++++++++++++++++
 tb/tb_i2c_read_data_b.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_b_pkg.sv
// Shared definitions for the D8M configuration-bus read stage.
// Holds the debug state codes (same ST code space as the pointer writer),
// the bit-phase and STOP-step encodings, the frame length per byte and a
// couple of small helpers used by the read master.
package i2c_b_pkg;

   // Base codes for the shared ST debug view. BIT occupies codes 2..5
   // (one per phase) and STOP occupies 6..8 (one per step).
   typedef enum logic [7:0] {
      ST_IDLE  = 8'd0,
      ST_START = 8'd1,
      ST_BIT   = 8'd2,
      ST_STOP  = 8'd6,
      ST_DONE  = 8'd9
   } state_t;

   // Bit phases inside ST_BIT.
   localparam logic [1:0] PH_SCL_LOW  = 2'd0;
   localparam logic [1:0] PH_SDA_SET  = 2'd1;
   localparam logic [1:0] PH_SCL_HIGH = 2'd2;
   localparam logic [1:0] PH_SAMPLE   = 2'd3;

   // STOP steps inside ST_STOP (reuses the phase counter).
   localparam logic [1:0] STOP_BOTH_LOW = 2'd0;
   localparam logic [1:0] STOP_SCL_HIGH = 2'd1;
   localparam logic [1:0] STOP_SDA_HIGH = 2'd2;

   // Eight data bits plus the acknowledge slot.
   localparam int unsigned BITS_PER_BYTE = 9;
   localparam logic [3:0]  ACK_SLOT      = 4'(BITS_PER_BYTE - 1);

   // Shift-out frame for a received byte: data bits released, then the
   // master's own acknowledge (0 = ACK, 1 = NACK on the final byte).
   function automatic logic [8:0] read_byte_frame(input logic last);
      return {8'hFF, last};
   endfunction

   // Debug code: BIT and STOP expose their phase/step in the low bits.
   function automatic logic [7:0] st_code(input state_t s, input logic [1:0] ph);
      logic [7:0] c;
      c = s;
      if (s == ST_BIT || s == ST_STOP) begin
         c = c + {6'd0, ph};
      end
      return c;
   endfunction

endpackage

// File: rtl/i2c_byte_shifter_b.sv
// 9-bit frame shifter for the read master.
// Loads an outgoing frame, presents its MSB for SDA drive and shifts the
// sampled bus bit in at the LSB, so after eight shifts the low byte holds
// the received data while the MSB holds the acknowledge-slot drive.
//   clk        bit-phase tick
//   reset_n    asynchronous active-low reset
//   load       load load_value (wins over shift)
//   load_value frame to load
//   shift      shift left, sdai enters at bit 0
//   sdai       sampled bus SDA
//   value      current register contents (value[8] is the drive bit)
module i2c_byte_shifter_b (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [8:0] load_value,
   input  logic       shift,
   input  logic       sdai,
   output logic [8:0] value
);

   logic [8:0] sr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr <= '1;
      end else if (load) begin
         sr <= load_value;
      end else if (shift) begin
         sr <= {sr[7:0], sdai};
      end
   end

   assign value = sr;

endmodule

// File: rtl/i2c_read_data_b.sv
// I2C master read stage for the D8M configuration bus.
// After the pointer write, issues START, address with R/W=1, reads BYTES
// data bytes (ACK all but the last, NACK the last) and sends STOP. An
// address NACK retries up to MAX_TRY attempts in total.
//   PT_CK          bit-phase tick; every rising edge advances one phase
//   RESET_N        asynchronous active-low reset
//   GO             request; a 0->1 seen while idle starts a transaction
//   SLAVE_ADDRESS  8-bit write address, bit0 replaced by 1 (read)
//   SDAI           sampled bus SDA
//   SDAO / SCLO    open-drain drives (1 = release)
//   END_OK         1 = idle/done, 0 = busy
//   ACK_OK         1 = last attempt's address was ACKed
//   DATA           read data, first byte in the top byte, MSB first
//   ST             debug state code
module i2c_read_data_b
   import i2c_b_pkg::*;
#(
   parameter int unsigned BYTES   = 2,
   parameter int unsigned MAX_TRY = 3
) (
   input  logic               PT_CK,
   input  logic               RESET_N,
   input  logic               GO,
   input  logic [7:0]         SLAVE_ADDRESS,
   input  logic               SDAI,
   output logic               SDAO,
   output logic               SCLO,
   output logic               END_OK,
   output logic               ACK_OK,
   output logic [8*BYTES-1:0] DATA,
   output logic [7:0]         ST
);

   localparam logic [2:0] LAST_BYTE = 3'(BYTES);
   localparam logic [4:0] TRY_LIMIT = 5'(MAX_TRY);

   state_t             state, state_nxt;
   logic [1:0]         phase, phase_nxt;
   logic [3:0]         bit_cnt, bit_cnt_nxt;
   logic [2:0]         byte_cnt, byte_cnt_nxt;
   logic [3:0]         try_cnt, try_cnt_nxt;
   logic               retry, retry_nxt;
   logic               go_d;
   logic [8*BYTES-1:0] shadow, shadow_nxt;

   logic               sdao_nxt, sclo_nxt, end_ok_nxt, ack_ok_nxt;
   logic [8*BYTES-1:0] data_nxt;

   logic               sh_load, sh_shift;
   logic [8:0]         sh_load_value;
   logic [8:0]         sh_value;

   logic               go_rise;
   logic               byte_end;
   logic               next_is_last;
   logic               retry_more;
   logic               addr_rw_unused;

   assign go_rise        = GO & ~go_d;
   assign byte_end       = (state == ST_BIT) && (phase == PH_SAMPLE) && (bit_cnt == ACK_SLOT);
   assign next_is_last   = (byte_cnt + 3'd1) == LAST_BYTE;
   assign retry_more     = ({1'b0, try_cnt} + 5'd1) < TRY_LIMIT;
   assign addr_rw_unused = SLAVE_ADDRESS[0];

   i2c_byte_shifter_b u_shifter (
      .clk        (PT_CK),
      .reset_n    (RESET_N),
      .load       (sh_load),
      .load_value (sh_load_value),
      .shift      (sh_shift),
      .sdai       (SDAI),
      .value      (sh_value)
   );

   // State and output registers.
   always_ff @(posedge PT_CK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= ST_IDLE;
         phase    <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         try_cnt  <= '0;
         retry    <= 1'b0;
         go_d     <= 1'b0;
         shadow   <= '0;
         SDAO     <= 1'b1;
         SCLO     <= 1'b1;
         END_OK   <= 1'b1;
         ACK_OK   <= 1'b0;
         DATA     <= '0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         bit_cnt  <= bit_cnt_nxt;
         byte_cnt <= byte_cnt_nxt;
         try_cnt  <= try_cnt_nxt;
         retry    <= retry_nxt;
         go_d     <= GO;
         shadow   <= shadow_nxt;
         SDAO     <= sdao_nxt;
         SCLO     <= sclo_nxt;
         END_OK   <= end_ok_nxt;
         ACK_OK   <= ack_ok_nxt;
         DATA     <= data_nxt;
      end
   end

   // Next-state logic: sequencing, bit/byte counters and retry bookkeeping.
   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      bit_cnt_nxt  = bit_cnt;
      byte_cnt_nxt = byte_cnt;
      try_cnt_nxt  = try_cnt;
      retry_nxt    = retry;
      case (state)
         ST_IDLE: begin
            if (go_rise) begin
               state_nxt   = ST_START;
               try_cnt_nxt = '0;
               retry_nxt   = 1'b0;
            end
         end
         ST_START: begin
            state_nxt    = ST_BIT;
            phase_nxt    = PH_SCL_LOW;
            bit_cnt_nxt  = '0;
            byte_cnt_nxt = '0;
            retry_nxt    = 1'b0;
         end
         ST_BIT: begin
            phase_nxt = phase + 2'd1;
            if (phase == PH_SAMPLE) begin
               if (bit_cnt == ACK_SLOT) begin
                  bit_cnt_nxt = '0;
                  if (byte_cnt == 3'd0 && SDAI) begin
                     state_nxt = ST_STOP;
                     phase_nxt = STOP_BOTH_LOW;
                     retry_nxt = 1'b1;
                  end else if (byte_cnt == LAST_BYTE) begin
                     state_nxt = ST_STOP;
                     phase_nxt = STOP_BOTH_LOW;
                  end else begin
                     byte_cnt_nxt = byte_cnt + 3'd1;
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end
         end
         ST_STOP: begin
            phase_nxt = phase + 2'd1;
            if (phase == STOP_SDA_HIGH) begin
               state_nxt = ST_DONE;
               phase_nxt = '0;
               // retry stays set only when another attempt follows; DONE
               // then doubles as the one idle bus phase before re-START.
               if (retry && retry_more) begin
                  try_cnt_nxt = try_cnt + 4'd1;
               end else begin
                  retry_nxt = 1'b0;
               end
            end
         end
         ST_DONE: begin
            state_nxt    = retry ? ST_START : ST_IDLE;
            phase_nxt    = '0;
            bit_cnt_nxt  = '0;
            byte_cnt_nxt = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
         end
      endcase
   end

   // Output logic: bus drives, handshake, shifter control and data capture.
   always_comb begin
      sdao_nxt      = SDAO;
      sclo_nxt      = SCLO;
      end_ok_nxt    = END_OK;
      ack_ok_nxt    = ACK_OK;
      data_nxt      = DATA;
      shadow_nxt    = shadow;
      sh_load       = 1'b0;
      sh_shift      = 1'b0;
      sh_load_value = read_byte_frame(next_is_last);
      case (state)
         ST_IDLE: begin
            sdao_nxt = 1'b1;
            sclo_nxt = 1'b1;
            if (go_rise) begin
               end_ok_nxt    = 1'b0;
               sh_load       = 1'b1;
               sh_load_value = {SLAVE_ADDRESS[7:1], 2'b11};
            end
         end
         ST_START: begin
            sdao_nxt = 1'b0;
         end
         ST_BIT: begin
            case (phase)
               PH_SCL_LOW:  sclo_nxt = 1'b0;
               PH_SDA_SET:  sdao_nxt = sh_value[8];
               PH_SCL_HIGH: sclo_nxt = 1'b1;
               default: begin
                  sh_shift = 1'b1;
                  if (byte_end) begin
                     if (byte_cnt == 3'd0) begin
                        ack_ok_nxt = ~SDAI;
                        sh_load    = ~SDAI;
                     end else begin
                        // Low byte of the shifter holds the eight received bits.
                        for (int unsigned i = 0; i < BYTES; i++) begin
                           if (byte_cnt == 3'(i + 1)) begin
                              shadow_nxt[8*(BYTES-1-i) +: 8] = sh_value[7:0];
                           end
                        end
                        sh_load = (byte_cnt != LAST_BYTE);
                     end
                  end
               end
            endcase
         end
         ST_STOP: begin
            case (phase)
               STOP_BOTH_LOW: begin
                  sdao_nxt = 1'b0;
                  sclo_nxt = 1'b0;
               end
               STOP_SCL_HIGH: sclo_nxt = 1'b1;
               default: begin
                  sdao_nxt = 1'b1;
                  sclo_nxt = 1'b1;
                  if (!(retry && retry_more)) begin
                     end_ok_nxt = 1'b1;
                  end
                  if (!retry) begin
                     data_nxt = shadow;
                  end
               end
            endcase
         end
         default: begin
         end
      endcase
   end

   assign ST = st_code(state, phase);

endmodule

// File: tb/tb_i2c_read_data_b.sv
module tb_i2c_read_data_b;

   logic        pt_ck = 1'b0;
   logic        reset_n = 1'b0;
   logic        go_a = 1'b0;
   logic        go_b = 1'b0;
   logic        sdao_a, sclo_a, end_ok_a, ack_ok_a;
   logic        sdao_b, sclo_b, end_ok_b, ack_ok_b;
   logic [15:0] data_a;
   logic [7:0]  data_b;
   logic [7:0]  st_a, st_b;

   // Wired-AND bus shared by both masters and the slave model.
   logic sda_m, sda_bus, scl_bus;
   logic slv_drive = 1'b1;
   assign sda_m   = sdao_a & sdao_b;
   assign sda_bus = sda_m & slv_drive;
   assign scl_bus = sclo_a & sclo_b;

   int checks = 0;
   int failures = 0;

   i2c_read_data_b #(.BYTES(2), .MAX_TRY(3)) dut_a (
      .PT_CK(pt_ck), .RESET_N(reset_n), .GO(go_a), .SLAVE_ADDRESS(8'hDA),
      .SDAI(sda_bus), .SDAO(sdao_a), .SCLO(sclo_a), .END_OK(end_ok_a),
      .ACK_OK(ack_ok_a), .DATA(data_a), .ST(st_a)
   );

   i2c_read_data_b #(.BYTES(1), .MAX_TRY(3)) dut_b (
      .PT_CK(pt_ck), .RESET_N(reset_n), .GO(go_b), .SLAVE_ADDRESS(8'h34),
      .SDAI(sda_bus), .SDAO(sdao_b), .SCLO(sclo_b), .END_OK(end_ok_b),
      .ACK_OK(ack_ok_b), .DATA(data_b), .ST(st_b)
   );

   always #5 pt_ck = ~pt_ck;

   // Slave model, sampling the bus mid-cycle.
   int          rise_cnt = 0, start_cnt = 0, stop_cnt = 0, addr_slot_cnt = 0;
   int          nack_until = 0, slv_nbytes = 2;
   logic [31:0] slv_bits = '0;
   logic        acked = 1'b0;
   logic        sda_q = 1'b1, scl_q = 1'b1;
   logic [8:0]  addr_seen = '0;
   logic [4:0]  mack_v = '0;

   always @(negedge pt_ck) begin
      sda_q <= sda_bus;
      scl_q <= scl_bus;
      if (!reset_n) begin
         slv_drive <= 1'b1;
         acked     <= 1'b0;
         rise_cnt  <= 0;
      end else if (scl_q && scl_bus && sda_q && !sda_bus) begin
         start_cnt <= start_cnt + 1;
         rise_cnt  <= 0;
         acked     <= 1'b0;
         slv_drive <= 1'b1;
      end else if (scl_q && scl_bus && !sda_q && sda_bus) begin
         stop_cnt  <= stop_cnt + 1;
         slv_drive <= 1'b1;
      end else if (!scl_q && scl_bus) begin
         if (rise_cnt < 9) addr_seen[4'(8 - rise_cnt)] <= sda_m;
         else if (rise_cnt / 9 <= 4 && rise_cnt % 9 == 8) mack_v[3'(rise_cnt / 9)] <= sda_m;
         rise_cnt <= rise_cnt + 1;
      end else if (scl_q && !scl_bus) begin
         if (rise_cnt == 8) begin
            addr_slot_cnt <= addr_slot_cnt + 1;
            if (addr_slot_cnt < nack_until) slv_drive <= 1'b1;
            else begin
               slv_drive <= 1'b0;
               acked     <= 1'b1;
            end
         end else if (acked && rise_cnt >= 9 && rise_cnt / 9 <= slv_nbytes && rise_cnt % 9 != 8)
            slv_drive <= slv_bits[5'(31 - 8 * (rise_cnt / 9 - 1) - rise_cnt % 9)];
         else
            slv_drive <= 1'b1;
      end
   end

   // Pulses (or raises and holds) GO and counts edges from acceptance to END_OK high.
   task automatic run_txn(input bit sel_b, input bit hold, output int lat, output bit low_seen);
      repeat (3) @(negedge pt_ck);
      if (sel_b) go_b = 1'b1;
      else go_a = 1'b1;
      @(posedge pt_ck);
      #1;
      low_seen = sel_b ? !end_ok_b : !end_ok_a;
      if (!hold) begin
         go_a = 1'b0;
         go_b = 1'b0;
      end
      lat = -1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge pt_ck);
         #1;
         if ((sel_b ? end_ok_b : end_ok_a) === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge pt_ck);
      checks++; if (sdao_a !== 1'b1) begin failures++; $display("FAIL reset_sdao got=%b exp=1", sdao_a); end
      checks++; if (sclo_a !== 1'b1) begin failures++; $display("FAIL reset_sclo got=%b exp=1", sclo_a); end
      checks++; if (end_ok_a !== 1'b1) begin failures++; $display("FAIL reset_end_ok got=%b exp=1", end_ok_a); end
      checks++; if (ack_ok_a !== 1'b0) begin failures++; $display("FAIL reset_ack_ok got=%b exp=0", ack_ok_a); end
      checks++; if (data_a !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_a); end
      checks++; if (st_a !== 8'd0) begin failures++; $display("FAIL reset_st got=%0d exp=0", st_a); end
      reset_n = 1'b1;
      repeat (4) @(posedge pt_ck);
      #1;
      checks++; if (end_ok_a !== 1'b1 || sdao_a !== 1'b1 || sclo_a !== 1'b1) begin
         failures++; $display("FAIL idle_after_reset got=%b%b%b exp=111", end_ok_a, sdao_a, sclo_a);
      end
   endtask

   task automatic test_read_two;
      int lat; bit low; int s0;
      slv_nbytes = 2; slv_bits = 32'h1234_0000; nack_until = addr_slot_cnt;
      s0 = start_cnt;
      run_txn(1'b0, 1'b0, lat, low);
      checks++; if (!low) begin failures++; $display("FAIL read2_busy got=end_ok_high exp=end_ok_low"); end
      checks++; if (lat !== 112) begin failures++; $display("FAIL read2_latency got=%0d exp=112", lat); end
      checks++; if (addr_seen !== 9'h1B7) begin failures++; $display("FAIL read2_addr got=%h exp=1b7", addr_seen); end
      checks++; if (mack_v[1] !== 1'b0) begin failures++; $display("FAIL read2_ack_byte1 got=%b exp=0", mack_v[1]); end
      checks++; if (mack_v[2] !== 1'b1) begin failures++; $display("FAIL read2_nack_byte2 got=%b exp=1", mack_v[2]); end
      checks++; if (data_a !== 16'h1234) begin failures++; $display("FAIL read2_data got=%h exp=1234", data_a); end
      checks++; if (ack_ok_a !== 1'b1) begin failures++; $display("FAIL read2_ack_ok got=%b exp=1", ack_ok_a); end
      checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL read2_starts got=%0d exp=1", start_cnt - s0); end
   endtask

   task automatic test_nack_all;
      int lat; bit low; int s0; int p0;
      slv_bits = 32'hFFFF_0000; nack_until = addr_slot_cnt + 100;
      s0 = start_cnt; p0 = stop_cnt;
      run_txn(1'b0, 1'b0, lat, low);
      nack_until = addr_slot_cnt;
      checks++; if (lat !== 122) begin failures++; $display("FAIL nack_latency got=%0d exp=122", lat); end
      checks++; if (start_cnt - s0 !== 3) begin failures++; $display("FAIL nack_starts got=%0d exp=3", start_cnt - s0); end
      checks++; if (stop_cnt - p0 !== 3) begin failures++; $display("FAIL nack_stops got=%0d exp=3", stop_cnt - p0); end
      checks++; if (ack_ok_a !== 1'b0) begin failures++; $display("FAIL nack_ack_ok got=%b exp=0", ack_ok_a); end
      checks++; if (data_a !== 16'h1234) begin failures++; $display("FAIL nack_data_kept got=%h exp=1234", data_a); end
   endtask

   task automatic test_retry;
      int lat; bit low; int s0;
      slv_bits = 32'h5AC3_0000; nack_until = addr_slot_cnt + 2;
      s0 = start_cnt;
      run_txn(1'b0, 1'b0, lat, low);
      checks++; if (lat !== 194) begin failures++; $display("FAIL retry_latency got=%0d exp=194", lat); end
      checks++; if (start_cnt - s0 !== 3) begin failures++; $display("FAIL retry_starts got=%0d exp=3", start_cnt - s0); end
      checks++; if (data_a !== 16'h5AC3) begin failures++; $display("FAIL retry_data got=%h exp=5ac3", data_a); end
      checks++; if (ack_ok_a !== 1'b1) begin failures++; $display("FAIL retry_ack_ok got=%b exp=1", ack_ok_a); end
   endtask

   task automatic test_go_held;
      int lat; bit low; int s0; bit dropped;
      slv_bits = 32'hBEEF_0000; nack_until = addr_slot_cnt;
      s0 = start_cnt; dropped = 1'b0;
      run_txn(1'b0, 1'b1, lat, low);
      checks++; if (lat !== 112) begin failures++; $display("FAIL held_latency got=%0d exp=112", lat); end
      checks++; if (data_a !== 16'hBEEF) begin failures++; $display("FAIL held_data got=%h exp=beef", data_a); end
      repeat (60) begin
         @(posedge pt_ck); #1;
         if (end_ok_a !== 1'b1) dropped = 1'b1;
      end
      checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL held_no_retrigger got=busy exp=idle"); end
      checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL held_starts got=%0d exp=1", start_cnt - s0); end
      @(negedge pt_ck); go_a = 1'b0;
      repeat (2) @(negedge pt_ck);
      slv_bits = 32'h4321_0000;
      run_txn(1'b0, 1'b0, lat, low);
      repeat (20) @(posedge pt_ck);
      #1;
      checks++; if (lat !== 112) begin failures++; $display("FAIL rerise_latency got=%0d exp=112", lat); end
      checks++; if (start_cnt - s0 !== 2) begin failures++; $display("FAIL rerise_starts got=%0d exp=2", start_cnt - s0); end
      checks++; if (data_a !== 16'h4321) begin failures++; $display("FAIL rerise_data got=%h exp=4321", data_a); end
   endtask

   task automatic test_reset_mid;
      slv_bits = 32'h0000_0000; nack_until = addr_slot_cnt;
      repeat (3) @(negedge pt_ck);
      go_a = 1'b1;
      @(posedge pt_ck);
      #1 go_a = 1'b0;
      repeat (40) @(posedge pt_ck);
      #1;
      checks++; if (sclo_a !== 1'b1 || end_ok_a !== 1'b0) begin
         failures++; $display("FAIL mid_before_reset got=sclo%b end_ok%b exp=sclo1 end_ok0", sclo_a, end_ok_a);
      end
      reset_n = 1'b0;
      #1;
      checks++; if (sdao_a !== 1'b1 || sclo_a !== 1'b1) begin
         failures++; $display("FAIL mid_reset_bus got=%b%b exp=11", sdao_a, sclo_a);
      end
      checks++; if (end_ok_a !== 1'b1) begin failures++; $display("FAIL mid_reset_end_ok got=%b exp=1", end_ok_a); end
      checks++; if (data_a !== 16'h0000) begin failures++; $display("FAIL mid_reset_data got=%h exp=0000", data_a); end
      checks++; if (st_a !== 8'd0) begin failures++; $display("FAIL mid_reset_st got=%0d exp=0", st_a); end
      checks++; if (ack_ok_a !== 1'b0) begin failures++; $display("FAIL mid_reset_ack_ok got=%b exp=0", ack_ok_a); end
      repeat (3) @(negedge pt_ck);
      reset_n = 1'b1;
      repeat (3) @(posedge pt_ck);
   endtask

   task automatic test_one_byte;
      int lat; bit low;
      slv_nbytes = 1; slv_bits = 32'hA500_0000; nack_until = addr_slot_cnt;
      run_txn(1'b1, 1'b0, lat, low);
      checks++; if (!low) begin failures++; $display("FAIL one_busy got=end_ok_high exp=end_ok_low"); end
      checks++; if (lat !== 76) begin failures++; $display("FAIL one_latency got=%0d exp=76", lat); end
      checks++; if (addr_seen !== 9'h06B) begin failures++; $display("FAIL one_addr got=%h exp=06b", addr_seen); end
      checks++; if (mack_v[1] !== 1'b1) begin failures++; $display("FAIL one_nack got=%b exp=1", mack_v[1]); end
      checks++; if (data_b !== 8'hA5) begin failures++; $display("FAIL one_data got=%h exp=a5", data_b); end
      checks++; if (ack_ok_b !== 1'b1) begin failures++; $display("FAIL one_ack_ok got=%b exp=1", ack_ok_b); end
   endtask

   initial begin
      test_reset;
      test_read_two;
      test_nack_all;
      test_retry;
      test_go_held;
      test_reset_mid;
      test_one_byte;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
